hazard_ctrl: RTL and testbench

- Central stall/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the D-stage instruction class flags from the type decoder plus the register fields.
- Tracks a destination-register / Tnew scoreboard for E, M and W in its own pipeline registers.
- Drives the D-freeze/E-bubble stall and the forwarding-mux selects for the D, E and M stages.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_tuse_tnew.sv | 46 ++++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forward-select
// encodings, Tuse/Tnew values and the jal link register.
package hazard_pkg;

   // Forward-mux select encodings, shared by the D, E and M consumers
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   // Tuse / Tnew values; T_NONE marks an operand the instruction never reads
   localparam logic [1:0] T0     = 2'd0;
   localparam logic [1:0] T1     = 2'd1;
   localparam logic [1:0] T2     = 2'd2;
   localparam logic [1:0] T_NONE = 2'd3;

   // Link register written by jal
   localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/hazard_tuse_tnew.sv
// D-stage classifier: maps the instruction class flags to the destination
// register, the Tnew it carries into E and the Tuse of each source operand.
module hazard_tuse_tnew
   import hazard_pkg::*;
#(
   parameter int RA_W = 5,
   parameter int TN_W = 2
) (
   input  logic            d_rrcal,
   input  logic            d_rical,
   input  logic            d_lm,
   input  logic            d_sm,
   input  logic            d_b,
   input  logic            d_jal,
   input  logic            d_jr,
   input  logic [RA_W-1:0] d_rt,
   input  logic [RA_W-1:0] d_rd,
   output logic [RA_W-1:0] a3,
   output logic [TN_W-1:0] tnew,
   output logic [TN_W-1:0] tuse_rs,
   output logic [TN_W-1:0] tuse_rt
);

   // Class flags are one-hot; the if-chains only fix a deterministic order
   always_comb begin
      a3      = '0;
      tnew    = TN_W'(T0);
      tuse_rs = TN_W'(T_NONE);
      tuse_rt = TN_W'(T_NONE);

      if (d_rrcal)             a3 = d_rd;
      else if (d_rical || d_lm) a3 = d_rt;
      else if (d_jal)          a3 = RA_W'(REG_RA);

      if (d_rrcal || d_rical) tnew = TN_W'(T1);
      else if (d_lm)          tnew = TN_W'(T2);

      if (d_b || d_jr)                          tuse_rs = TN_W'(T0);
      else if (d_rrcal || d_rical || d_lm || d_sm) tuse_rs = TN_W'(T1);

      if (d_b)          tuse_rt = TN_W'(T0);
      else if (d_rrcal) tuse_rt = TN_W'(T1);
      else if (d_sm)    tuse_rt = TN_W'(T2);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline. Keeps its own E/M/W
// destination/Tnew scoreboard and derives the D-stage stall plus the forward
// selects for the D, E and M operand muxes.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int RA_W = 5,
   parameter int TN_W = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            d_rrcal,
   input  logic            d_rical,
   input  logic            d_lm,
   input  logic            d_sm,
   input  logic            d_b,
   input  logic            d_jal,
   input  logic            d_jr,
   input  logic [RA_W-1:0] d_rs,
   input  logic [RA_W-1:0] d_rt,
   input  logic [RA_W-1:0] d_rd,
   output logic            stall,
   output logic [1:0]      fwd_d_rs,
   output logic [1:0]      fwd_d_rt,
   output logic [1:0]      fwd_e_rs,
   output logic [1:0]      fwd_e_rt,
   output logic [1:0]      fwd_m_rt,
   output logic [RA_W-1:0] e_a3
);

   logic [RA_W-1:0] d_a3;
   logic [TN_W-1:0] d_tnew, d_tuse_rs, d_tuse_rt;

   logic [RA_W-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_a3_q, e_a3_d;
   logic [TN_W-1:0] e_tnew_q, e_tnew_d;
   logic [RA_W-1:0] m_rt_q, m_rt_d, m_a3_q, m_a3_d;
   logic [TN_W-1:0] m_tnew_q, m_tnew_d;
   logic [RA_W-1:0] w_a3_q, w_a3_d;

   logic rs_e, rs_m, rt_e, rt_m, rs_hz, rt_hz;

   hazard_tuse_tnew #(.RA_W(RA_W), .TN_W(TN_W)) u_tuse_tnew (
      .d_rrcal (d_rrcal),
      .d_rical (d_rical),
      .d_lm    (d_lm),
      .d_sm    (d_sm),
      .d_b     (d_b),
      .d_jal   (d_jal),
      .d_jr    (d_jr),
      .d_rt    (d_rt),
      .d_rd    (d_rd),
      .a3      (d_a3),
      .tnew    (d_tnew),
      .tuse_rs (d_tuse_rs),
      .tuse_rt (d_tuse_rt)
   );

   // $0 is hard-wired, so it never produces a dependency
   function automatic logic ra_match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
      return (a == b) && (a != '0);
   endfunction

   // Tnew counts down one per stage and bottoms out at 0
   function automatic logic [TN_W-1:0] tnew_dec(input logic [TN_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // D consumer: the nearest producer decides; a not-ready producer selects
   // the register file and the stall holds D until it is ready
   function automatic logic [1:0] sel_d(input logic me, input logic mm,
                                        input logic [TN_W-1:0] te, input logic [TN_W-1:0] tm);
      if (me)      return (te == '0) ? FWD_E : FWD_RF;
      else if (mm) return (tm == '0) ? FWD_M : FWD_RF;
      else         return FWD_RF;
   endfunction

   // E consumer: M is nearer than W; a not-ready M producer is picked up
   // later by the M-stage store-data forward
   function automatic logic [1:0] sel_e(input logic mm, input logic mw, input logic [TN_W-1:0] tm);
      if (mm)      return (tm == '0) ? FWD_M : FWD_RF;
      else if (mw) return FWD_W;
      else         return FWD_RF;
   endfunction

   // Stall and forward selects from the D fields and the registered scoreboard
   always_comb begin
      rs_e  = ra_match(d_rs, e_a3_q);
      rs_m  = ra_match(d_rs, m_a3_q);
      rt_e  = ra_match(d_rt, e_a3_q);
      rt_m  = ra_match(d_rt, m_a3_q);
      rs_hz = rs_e ? (d_tuse_rs < e_tnew_q) : (rs_m && (d_tuse_rs < m_tnew_q));
      rt_hz = rt_e ? (d_tuse_rt < e_tnew_q) : (rt_m && (d_tuse_rt < m_tnew_q));
      stall = rs_hz || rt_hz;

      fwd_d_rs = sel_d(rs_e, rs_m, e_tnew_q, m_tnew_q);
      fwd_d_rt = sel_d(rt_e, rt_m, e_tnew_q, m_tnew_q);
      fwd_e_rs = sel_e(ra_match(e_rs_q, m_a3_q), ra_match(e_rs_q, w_a3_q), m_tnew_q);
      fwd_e_rt = sel_e(ra_match(e_rt_q, m_a3_q), ra_match(e_rt_q, w_a3_q), m_tnew_q);
      fwd_m_rt = ra_match(m_rt_q, w_a3_q) ? FWD_W : FWD_RF;
      e_a3     = e_a3_q;
   end

   // Scoreboard advance: E takes D or a bubble on stall; M and W always move
   always_comb begin
      e_rs_d   = stall ? '0 : d_rs;
      e_rt_d   = stall ? '0 : d_rt;
      e_a3_d   = stall ? '0 : d_a3;
      e_tnew_d = stall ? '0 : d_tnew;
      m_rt_d   = e_rt_q;
      m_a3_d   = e_a3_q;
      m_tnew_d = tnew_dec(e_tnew_q);
      w_a3_d   = m_a3_q;
   end

   // Scoreboard registers; reset empties every stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         e_a3_q   <= '0;
         e_tnew_q <= '0;
         m_rt_q   <= '0;
         m_a3_q   <= '0;
         m_tnew_q <= '0;
         w_a3_q   <= '0;
      end else begin
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         e_a3_q   <= e_a3_d;
         e_tnew_q <= e_tnew_d;
         m_rt_q   <= m_rt_d;
         m_a3_q   <= m_a3_d;
         m_tnew_q <= m_tnew_d;
         w_a3_q   <= w_a3_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of D-stage instructions with the
// hand-derived stall/forward outputs for each cycle, plus a reset-mid-stall
// sequence.
module tb_hazard_ctrl;

   // Flag vector order: {rrcal, rical, lm, sm, b, jal, jr}
   localparam logic [6:0] NOP = 7'b0000000;
   localparam logic [6:0] RR  = 7'b1000000;
   localparam logic [6:0] RI  = 7'b0100000;
   localparam logic [6:0] LM  = 7'b0010000;
   localparam logic [6:0] SM  = 7'b0001000;
   localparam logic [6:0] BR  = 7'b0000100;
   localparam logic [6:0] JAL = 7'b0000010;
   localparam logic [6:0] JR  = 7'b0000001;

   typedef struct {
      logic [6:0] fl;
      logic [4:0] rs, rt, rd;
      logic       st;
      logic [1:0] dr, dt, er, et, mt;
      logic [4:0] ea3;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       d_rrcal, d_rical, d_lm, d_sm, d_b, d_jal, d_jr;
   logic [4:0] d_rs, d_rt, d_rd;
   logic       stall;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
   logic [4:0] e_a3;

   int n_run  = 0;
   int n_fail = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.RA_W(5), .TN_W(2)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .d_rrcal  (d_rrcal),
      .d_rical  (d_rical),
      .d_lm     (d_lm),
      .d_sm     (d_sm),
      .d_b      (d_b),
      .d_jal    (d_jal),
      .d_jr     (d_jr),
      .d_rs     (d_rs),
      .d_rt     (d_rt),
      .d_rd     (d_rd),
      .stall    (stall),
      .fwd_d_rs (fwd_d_rs),
      .fwd_d_rt (fwd_d_rt),
      .fwd_e_rs (fwd_e_rs),
      .fwd_e_rt (fwd_e_rt),
      .fwd_m_rt (fwd_m_rt),
      .e_a3     (e_a3)
   );

   function automatic vec_t mk(input logic [6:0] fl, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic st, input logic [1:0] dr,
                               input logic [1:0] dt, input logic [1:0] er, input logic [1:0] et,
                               input logic [1:0] mt, input logic [4:0] ea3);
      vec_t v;
      v.fl = fl; v.rs = rs; v.rt = rt; v.rd = rd;
      v.st = st; v.dr = dr; v.dt = dt; v.er = er; v.et = et; v.mt = mt; v.ea3 = ea3;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] fl, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      {d_rrcal, d_rical, d_lm, d_sm, d_b, d_jal, d_jr} = fl;
      d_rs = rs;
      d_rt = rt;
      d_rd = rd;
   endtask

   task automatic chk_all(input string tag, input logic st, input logic [1:0] dr, input logic [1:0] dt,
                          input logic [1:0] er, input logic [1:0] et, input logic [1:0] mt,
                          input logic [4:0] ea3);
      chk({tag, ".stall"},    32'(stall),    32'(st));
      chk({tag, ".fwd_d_rs"}, 32'(fwd_d_rs), 32'(dr));
      chk({tag, ".fwd_d_rt"}, 32'(fwd_d_rt), 32'(dt));
      chk({tag, ".fwd_e_rs"}, 32'(fwd_e_rs), 32'(er));
      chk({tag, ".fwd_e_rt"}, 32'(fwd_e_rt), 32'(et));
      chk({tag, ".fwd_m_rt"}, 32'(fwd_m_rt), 32'(mt));
      chk({tag, ".e_a3"},     32'(e_a3),     32'(ea3));
   endtask

   initial begin
      // fl, rs, rt, rd | stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, e_a3
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // lw $8 ; add $9,$8,$1 : one bubble, then W->E forward
      vecs.push_back(mk(LM,  2, 8, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(RR,  8, 1, 9, 1, 0, 0, 0, 0, 0, 8));
      vecs.push_back(mk(RR,  8, 1, 9, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 3, 0, 0, 9));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // lw $8 ; beq $8,$0 : two bubbles, no D forward afterwards
      vecs.push_back(mk(LM,  2, 8, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(BR,  8, 0, 0, 1, 0, 0, 0, 0, 0, 8));
      vecs.push_back(mk(BR,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(BR,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // add $3,$1,$2 ; sw $3,0($4) : M->E then W->M store data
      vecs.push_back(mk(RR,  1, 2, 3, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(SM,  4, 3, 0, 0, 0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
      // jal ; jr $31 : E->D forward, no stall
      vecs.push_back(mk(JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 31, 0, 0, 0, 1, 0, 0, 0, 0, 31));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // ori $0,$1,5 ; add $2,$0,$0 : $0 never matches
      vecs.push_back(mk(RI,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(RR,  0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // ori $5 ; add $5 ; add $6,$5,$0 : E (not ready) beats M (ready)
      vecs.push_back(mk(RI,  1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(RR,  2, 3, 5, 0, 0, 0, 0, 0, 0, 5));
      vecs.push_back(mk(RR,  5, 0, 6, 0, 0, 0, 0, 0, 0, 5));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 2, 0, 0, 6));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // ori $31 ; jal ; jr $31 : E (ready) beats M
      vecs.push_back(mk(RI,  1, 31, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31));
      vecs.push_back(mk(JR, 31, 0, 0, 0, 1, 0, 0, 0, 0, 31));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // lw $7 ; sw $7 : Tuse_rt 2 == Tnew 2, no stall, W->M store data
      vecs.push_back(mk(LM,  1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(SM,  2, 7, 0, 0, 0, 0, 0, 0, 0, 7));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
      vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Power-on reset with a NOP in D
      reset_n = 1'b0;
      drive(NOP, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;

      // Table: one D instruction per cycle, outputs sampled at the falling edge
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         drive(vecs[i].fl, vecs[i].rs, vecs[i].rt, vecs[i].rd);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].dr, vecs[i].dt,
                 vecs[i].er, vecs[i].et, vecs[i].mt, vecs[i].ea3);
      end

      // Reset asserted while a load-use stall is active
      @(posedge clk);
      #1;
      drive(LM, 2, 8, 0);
      @(posedge clk);
      #1;
      drive(RR, 8, 1, 9);
      #2;
      chk("rst_pre.stall", 32'(stall), 32'd1);
      chk("rst_pre.e_a3",  32'(e_a3),  32'd8);
      reset_n = 1'b0;
      #1;
      chk("rst_async.stall", 32'(stall), 32'd0);
      chk("rst_async.e_a3",  32'(e_a3),  32'd0);
      @(posedge clk);
      #1;
      drive(NOP, 0, 0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk_all("rst_rel0", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk_all("rst_rel1", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk_all("rst_rel2", 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
